// File: rtl/fighter_pkg.sv
// Shared fighter definitions used by the animation controllers and sprite blocks.
// Contents: character state encoding (8-bit, 0..6), game state encoding and the
// default per-state frame counts.
package fighter_pkg;

   typedef enum logic [7:0] {
      CS_STAND   = 8'd0,
      CS_ATTACK  = 8'd1,
      CS_MOVEL   = 8'd2,
      CS_MOVER   = 8'd3,
      CS_DEFENSE = 8'd4,
      CS_HURT    = 8'd5,
      CS_DIE     = 8'd6
   } char_state_e;

   typedef enum logic [7:0] {
      GS_START = 8'd0,
      GS_GAME  = 8'd1,
      GS_OVER  = 8'd2
   } game_state_e;

   localparam int DEF_FRAME_DIV      = 4;
   localparam int DEF_STAND_FRAMES   = 9;
   localparam int DEF_MOVEL_FRAMES   = 10;
   localparam int DEF_MOVER_FRAMES   = 9;
   localparam int DEF_ATTACK_FRAMES  = 6;
   localparam int DEF_DEFENSE_FRAMES = 1;
   localparam int DEF_HURT_FRAMES    = 5;
   localparam int DEF_DIE_FRAMES     = 5;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame strobe edge detector and animation divider.
// Ports: Clk, Reset (sync, active-high), frame_clk (level strobe),
//        clear (forces the divider to 0), tick (one Clk per frame_clk rise,
//        registered), advance (tick on which the divider sits at FRAME_DIV-1).
module frame_tick_gen
   import fighter_pkg::*;
#(
   parameter int FRAME_DIV = DEF_FRAME_DIV
) (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   input  logic clear,
   output logic tick,
   output logic advance
);

   localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

   logic       frame_clk_d_r;
   logic       tick_r;
   logic [7:0] div_r;

   // Edge detector and divider registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_clk_d_r <= 1'b0;
         tick_r        <= 1'b0;
         div_r         <= 8'd0;
      end else begin
         frame_clk_d_r <= frame_clk;
         tick_r        <= frame_clk & ~frame_clk_d_r;
         if (clear) begin
            div_r <= 8'd0;
         end else if (tick_r) begin
            div_r <= (div_r == DIV_LAST) ? 8'd0 : div_r + 8'd1;
         end else begin
            div_r <= div_r;
         end
      end
   end

   assign tick    = tick_r;
   assign advance = tick_r & (div_r == DIV_LAST);

endmodule

// File: rtl/iori_anim_ctrl.sv
// Player-2 (Iori) animation and action controller.
// Ports: Clk, Reset (sync, active-high), frame_clk, game_state[7:0],
//        key_left/right/attack/defend, hit_in, die_in ->
//        character2_state[7:0], frame_num[7:0], one-hot action flags
//        (attack, character2_hurt, move_l2, move_r2, stand), die2, ko_done.
// All outputs come straight from registers.
module iori_anim_ctrl
   import fighter_pkg::*;
#(
   parameter int FRAME_DIV      = DEF_FRAME_DIV,
   parameter int STAND_FRAMES   = DEF_STAND_FRAMES,
   parameter int MOVEL_FRAMES   = DEF_MOVEL_FRAMES,
   parameter int MOVER_FRAMES   = DEF_MOVER_FRAMES,
   parameter int ATTACK_FRAMES  = DEF_ATTACK_FRAMES,
   parameter int DEFENSE_FRAMES = DEF_DEFENSE_FRAMES,
   parameter int HURT_FRAMES    = DEF_HURT_FRAMES,
   parameter int DIE_FRAMES     = DEF_DIE_FRAMES
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] game_state,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_attack,
   input  logic       key_defend,
   input  logic       hit_in,
   input  logic       die_in,
   output logic [7:0] character2_state,
   output logic [7:0] frame_num,
   output logic       attack,
   output logic       character2_hurt,
   output logic       move_l2,
   output logic       move_r2,
   output logic       stand,
   output logic       die2,
   output logic       ko_done
);

   function automatic logic [7:0] frames_of(input char_state_e s);
      case (s)
         CS_STAND:   frames_of = 8'(STAND_FRAMES);
         CS_ATTACK:  frames_of = 8'(ATTACK_FRAMES);
         CS_MOVEL:   frames_of = 8'(MOVEL_FRAMES);
         CS_MOVER:   frames_of = 8'(MOVER_FRAMES);
         CS_DEFENSE: frames_of = 8'(DEFENSE_FRAMES);
         CS_HURT:    frames_of = 8'(HURT_FRAMES);
         CS_DIE:     frames_of = 8'(DIE_FRAMES);
         default:    frames_of = 8'd1;
      endcase
   endfunction

   function automatic char_state_e key_select(input logic k_att, input logic k_def,
                                              input logic k_l, input logic k_r);
      if (k_att) begin
         key_select = CS_ATTACK;
      end else if (k_def) begin
         key_select = CS_DEFENSE;
      end else if (k_l ^ k_r) begin
         key_select = k_l ? CS_MOVEL : CS_MOVER;
      end else begin
         key_select = CS_STAND;
      end
   endfunction

   char_state_e state_r, state_nx, sel_s;
   logic [7:0]  frame_r, frame_nx, last_s;
   logic        hit_pending_r, hit_pending_nx, hit_eff_s;
   logic        ko_done_r, ko_done_nx;
   logic        attack_r, hurt_r, move_l_r, move_r_r, stand_r, die_r;
   logic        tick_s, advance_s, in_game_s;

   assign in_game_s = (game_state == 8'(GS_GAME));
   // A hit arriving in the advance cycle itself must be seen by that advance.
   assign hit_eff_s = hit_pending_r | hit_in;
   assign last_s    = frames_of(state_r) - 8'd1;

   frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .clear     (~in_game_s),
      .tick      (tick_s),
      .advance   (advance_s)
   );

   // Next-state, frame and pending-hit logic; leaving game overrides at once.
   always_comb begin
      state_nx       = state_r;
      frame_nx       = frame_r;
      hit_pending_nx = hit_eff_s;
      ko_done_nx     = ko_done_r;
      sel_s          = key_select(key_attack, key_defend, key_left, key_right);
      if (!in_game_s) begin
         state_nx       = CS_STAND;
         frame_nx       = 8'd0;
         hit_pending_nx = 1'b0;
         ko_done_nx     = 1'b0;
      end else if (advance_s && tick_s) begin
         if (die_in && (state_r != CS_DIE)) begin
            state_nx   = CS_DIE;
            frame_nx   = 8'd0;
            ko_done_nx = 1'b0;
         end else if (state_r == CS_DIE) begin
            // Pending hits stay latched but are ignored while down.
            if (frame_r < last_s) begin
               frame_nx = frame_r + 8'd1;
            end else begin
               ko_done_nx = 1'b1;
            end
         end else if (hit_eff_s && (state_r != CS_DEFENSE) && (state_r != CS_HURT)) begin
            state_nx       = CS_HURT;
            frame_nx       = 8'd0;
            hit_pending_nx = 1'b0;
         end else if (hit_eff_s && (state_r == CS_DEFENSE)) begin
            hit_pending_nx = 1'b0;
         end else if ((state_r == CS_ATTACK) || (state_r == CS_HURT)) begin
            if (frame_r >= last_s) begin
               state_nx = CS_STAND;
               frame_nx = 8'd0;
            end else begin
               frame_nx = frame_r + 8'd1;
            end
         end else begin
            if (sel_s == state_r) begin
               frame_nx = (frame_r >= last_s) ? 8'd0 : frame_r + 8'd1;
            end else begin
               state_nx = sel_s;
               frame_nx = 8'd0;
            end
         end
      end else begin
         state_nx = state_r;
      end
   end

   // State registers; action flags are registered from the next state so they
   // always match state_r.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r       <= CS_STAND;
         frame_r       <= 8'd0;
         hit_pending_r <= 1'b0;
         ko_done_r     <= 1'b0;
         attack_r      <= 1'b0;
         hurt_r        <= 1'b0;
         move_l_r      <= 1'b0;
         move_r_r      <= 1'b0;
         stand_r       <= 1'b1;
         die_r         <= 1'b0;
      end else begin
         state_r       <= state_nx;
         frame_r       <= frame_nx;
         hit_pending_r <= hit_pending_nx;
         ko_done_r     <= ko_done_nx;
         attack_r      <= (state_nx == CS_ATTACK);
         hurt_r        <= (state_nx == CS_HURT);
         move_l_r      <= (state_nx == CS_MOVEL);
         move_r_r      <= (state_nx == CS_MOVER);
         stand_r       <= (state_nx == CS_STAND);
         die_r         <= (state_nx == CS_DIE);
      end
   end

   assign character2_state = state_r;
   assign frame_num        = frame_r;
   assign attack           = attack_r;
   assign character2_hurt  = hurt_r;
   assign move_l2          = move_l_r;
   assign move_r2          = move_r_r;
   assign stand            = stand_r;
   assign die2             = die_r;
   assign ko_done          = ko_done_r;

endmodule

// File: tb/tb_iori_anim_ctrl.sv
// Self-checking bench for iori_anim_ctrl: table of per-advance vectors plus
// hand-written sequences for game-state override and mid-animation reset.
module tb_iori_anim_ctrl;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic [7:0] game_state;
   logic       key_left, key_right, key_attack, key_defend;
   logic       hit_in, die_in;
   logic [7:0] character2_state, frame_num;
   logic       attack, character2_hurt, move_l2, move_r2, stand, die2, ko_done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] keys;   // {attack, defend, left, right}
      logic       hit;
      logic       die;
      logic [7:0] exp_state;
      logic [7:0] exp_frame;
      logic       exp_ko;
   } vec_t;

   vec_t tbl[$];

   iori_anim_ctrl dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .frame_clk        (frame_clk),
      .game_state       (game_state),
      .key_left         (key_left),
      .key_right        (key_right),
      .key_attack       (key_attack),
      .key_defend       (key_defend),
      .hit_in           (hit_in),
      .die_in           (die_in),
      .character2_state (character2_state),
      .frame_num        (frame_num),
      .attack           (attack),
      .character2_hurt  (character2_hurt),
      .move_l2          (move_l2),
      .move_r2          (move_r2),
      .stand            (stand),
      .die2             (die2),
      .ko_done          (ko_done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] st, input logic [7:0] fr,
                          input logic ko);
      logic [5:0] exp_flags;
      exp_flags = {st == 8'd1, st == 8'd5, st == 8'd2, st == 8'd3, st == 8'd0, st == 8'd6};
      chk({tag, " state"}, 32'(character2_state), 32'(st));
      chk({tag, " frame"}, 32'(frame_num), 32'(fr));
      chk({tag, " flags"}, 32'({attack, character2_hurt, move_l2, move_r2, stand, die2}),
          32'(exp_flags));
      chk({tag, " ko_done"}, 32'(ko_done), 32'(ko));
   endtask

   task automatic add(input logic [3:0] k, input logic h, input logic d,
                      input logic [7:0] st, input logic [7:0] fr, input logic ko);
      vec_t v;
      v.keys = k; v.hit = h; v.die = d; v.exp_state = st; v.exp_frame = fr; v.exp_ko = ko;
      tbl.push_back(v);
   endtask

   // One frame_clk rise; tick fires one Clk after it is sampled.
   task automatic frame_edge();
      @(negedge Clk) frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic do_advance();
      repeat (4) frame_edge();
   endtask

   task automatic pulse_hit();
      @(negedge Clk) hit_in = 1'b1;
      @(negedge Clk) hit_in = 1'b0;
   endtask

   localparam logic [3:0] KA = 4'b1000, KD = 4'b0100, KL = 4'b0010, KR = 4'b0001, K0 = 4'b0000;
   localparam logic [7:0] S_ST = 8'd0, S_AT = 8'd1, S_ML = 8'd2, S_MR = 8'd3,
                          S_DF = 8'd4, S_HU = 8'd5, S_DI = 8'd6;

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; game_state = 8'd1;
      key_left = 1'b0; key_right = 1'b0; key_attack = 1'b0; key_defend = 1'b0;
      hit_in = 1'b0; die_in = 1'b0;

      // attack one-shot, key released mid-attack
      add(KA, 1'b0, 1'b0, S_AT, 8'd0, 1'b0);
      for (int i = 1; i <= 5; i++) add(K0, 1'b0, 1'b0, S_AT, 8'(i), 1'b0);
      add(K0, 1'b0, 1'b0, S_ST, 8'd0, 1'b0);
      // walk left, hit at frame 3 -> hurt, then back to stand
      for (int i = 0; i <= 3; i++) add(KL, 1'b0, 1'b0, S_ML, 8'(i), 1'b0);
      add(KL, 1'b1, 1'b0, S_HU, 8'd0, 1'b0);
      for (int i = 1; i <= 4; i++) add(KL, 1'b0, 1'b0, S_HU, 8'(i), 1'b0);
      add(KL, 1'b0, 1'b0, S_ST, 8'd0, 1'b0);
      add(KL, 1'b0, 1'b0, S_ML, 8'd0, 1'b0);
      add(KR, 1'b0, 1'b0, S_MR, 8'd0, 1'b0);
      add(KL | KR, 1'b0, 1'b0, S_ST, 8'd0, 1'b0);
      // defense blocks a hit; pending hit must be gone afterwards
      add(KD, 1'b0, 1'b0, S_DF, 8'd0, 1'b0);
      add(KD, 1'b1, 1'b0, S_DF, 8'd0, 1'b0);
      add(KD, 1'b0, 1'b0, S_DF, 8'd0, 1'b0);
      add(K0, 1'b0, 1'b0, S_ST, 8'd0, 1'b0);
      add(K0, 1'b0, 1'b0, S_ST, 8'd1, 1'b0);
      // die during attack frame 2, keys and hits ignored, hold last frame
      add(KA, 1'b0, 1'b0, S_AT, 8'd0, 1'b0);
      add(K0, 1'b0, 1'b0, S_AT, 8'd1, 1'b0);
      add(K0, 1'b0, 1'b0, S_AT, 8'd2, 1'b0);
      add(K0, 1'b0, 1'b1, S_DI, 8'd0, 1'b0);
      add(KA, 1'b1, 1'b1, S_DI, 8'd1, 1'b0);
      add(KL, 1'b1, 1'b1, S_DI, 8'd2, 1'b0);
      add(KD, 1'b0, 1'b1, S_DI, 8'd3, 1'b0);
      add(K0, 1'b0, 1'b1, S_DI, 8'd4, 1'b0);
      add(KA, 1'b1, 1'b1, S_DI, 8'd4, 1'b1);
      add(K0, 1'b0, 1'b1, S_DI, 8'd4, 1'b1);

      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      chk_all("reset", S_ST, 8'd0, 1'b0);

      // stand loop: 10 advances, frames 1..8,0,1
      for (int i = 1; i <= 10; i++) begin
         do_advance();
         chk_all($sformatf("stand_loop%0d", i), S_ST, 8'(i % 9), 1'b0);
      end

      foreach (tbl[i]) begin
         {key_attack, key_defend, key_left, key_right} = tbl[i].keys;
         die_in = tbl[i].die;
         if (tbl[i].hit) pulse_hit();
         do_advance();
         chk_all($sformatf("vec%0d", i), tbl[i].exp_state, tbl[i].exp_frame, tbl[i].exp_ko);
      end

      // leaving game forces stand one Clk later and drops the pending hit
      {key_attack, key_defend, key_left, key_right} = K0;
      @(negedge Clk) game_state = 8'd2;
      @(negedge Clk);
      chk_all("gameover", S_ST, 8'd0, 1'b0);
      die_in = 1'b0;
      @(negedge Clk) game_state = 8'd1;
      do_advance();
      chk_all("regame", S_ST, 8'd1, 1'b0);

      // reset in the middle of hurt, with the divider part-way through
      pulse_hit();
      do_advance();
      chk_all("hurt0", S_HU, 8'd0, 1'b0);
      do_advance();
      chk_all("hurt1", S_HU, 8'd1, 1'b0);
      repeat (2) frame_edge();
      @(negedge Clk) Reset = 1'b1;
      @(negedge Clk) Reset = 1'b0;
      chk_all("midreset", S_ST, 8'd0, 1'b0);
      repeat (3) frame_edge();
      chk_all("div_cleared", S_ST, 8'd0, 1'b0);
      frame_edge();
      chk_all("post_reset_adv", S_ST, 8'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
